// File: rtl/sweep_pkg.sv
// Shared encodings for the sweep counter: FSM states, sweep mode and count direction.
package sweep_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : sweep_pkg

// File: rtl/sweep_step.sv
// Combinational step of the sweep counter: the neighbouring value in the chosen
// direction, and whether the current value is the terminal value for that direction.
module sweep_step
    import sweep_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic [LENGTH-1:0] x_i,
    input  logic              dir_i,
    output logic [LENGTH-1:0] x_next_o,
    output logic              terminal_o
);

    // Modulo arithmetic already yields the wrap targets (all-ones -> 0, 0 -> all-ones).
    always_comb begin
        if (dir_i == DIR_DOWN) begin
            x_next_o   = x_i - LENGTH'(1);
            terminal_o = (x_i == '0);
        end else begin
            x_next_o   = x_i + LENGTH'(1);
            terminal_o = (x_i == '1);
        end
    end

endmodule : sweep_step

// File: rtl/sweep_counter.sv
// Controlled operand sweep generator: start/stop, up/down, preload, free-run wrap
// or one-shot sweep. Every output is a register.
module sweep_counter
    import sweep_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic              mode,
    input  logic              load,
    input  logic [LENGTH-1:0] load_val,
    output logic [LENGTH-1:0] x,
    output logic              busy,
    output logic              wrap,
    output logic              done,
    output state_e            state_dbg
);

    state_e            state_q, state_d;
    logic [LENGTH-1:0] x_q, x_d;
    logic              busy_q;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;

    logic [LENGTH-1:0] x_next;
    logic              terminal;

    sweep_step #(.LENGTH(LENGTH)) u_step (
        .x_i        (x_q),
        .dir_i      (dir),
        .x_next_o   (x_next),
        .terminal_o (terminal)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    // A preload replaces this edge's counting step, including completion.
                    state_d = ST_RUN;
                end else if (terminal && mode == MODE_ONESHOT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    x_d    = x_next;
                    wrap_d = terminal;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            x_d    = load_val;
            wrap_d = 1'b0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            busy_q  <= (state_d == ST_RUN);
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign x         = x_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule : sweep_counter
